// File: rtl/vault_ctrl.sv
// Vault controller: arbitrates store/retrieve requests, drives an external cipher engine,
// and keeps a small table of encrypted {code, key} entries with a failed-retrieve lockout.
module vault_ctrl #(
  parameter int unsigned ENTRIES = 10,
  parameter int unsigned TMO     = 255
) (
  input  logic        msclk,
  input  logic        rst,
  input  logic        st_req,
  input  logic        rt_req,
  input  logic [7:0]  key,
  input  logic [79:0] code_in,
  output logic        eng_start,
  output logic        eng_mode,
  output logic [7:0]  eng_key,
  output logic [79:0] eng_data,
  input  logic        eng_done,
  input  logic [79:0] eng_result,
  output logic        st_ack,
  output logic        rt_ack,
  output logic [79:0] code_out,
  output logic        result_ok,
  output logic [1:0]  fail_cnt,
  output logic        locked,
  output logic [3:0]  count
);

  localparam int unsigned     TmoW     = (TMO > 2) ? $clog2(TMO) : 1;
  localparam logic [3:0]      EntriesC = 4'(ENTRIES);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TMO - 1);

  typedef enum logic [2:0] {StIdle, StMatch, StIssue, StWait, StDone, StLock} state_e;

  state_e          state_q, state_d;
  logic [7:0]      key_q, key_d;
  logic [79:0]     code_q, code_d;
  logic            op_rt_q, op_rt_d;
  logic            last_rt_q, last_rt_d;
  logic            mode_q, mode_d;
  logic [3:0]      count_q, count_d;
  logic [1:0]      fail_q, fail_d;
  logic [79:0]     out_q, out_d;
  logic            ok_q, ok_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            grant_rt;
  logic            wr_en;
  logic            hit;

  logic [79:0] tbl_code_q [ENTRIES];
  logic [7:0]  tbl_key_q  [ENTRIES];

  // Only entries below count are live, so stale table contents never match.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (4'(i) < count_q && tbl_code_q[i] == code_q && tbl_key_q[i] == key_q) begin
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    code_d    = code_q;
    op_rt_d   = op_rt_q;
    last_rt_d = last_rt_q;
    mode_d    = mode_q;
    count_d   = count_q;
    fail_d    = fail_q;
    out_d     = out_q;
    ok_d      = ok_q;
    tmo_d     = tmo_q;
    grant_rt  = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (st_req || rt_req) begin
          // On contention grant whichever side did not win last time.
          grant_rt  = rt_req && (!st_req || !last_rt_q);
          key_d     = key;
          code_d    = code_in;
          op_rt_d   = grant_rt;
          last_rt_d = grant_rt;
          mode_d    = grant_rt;
          if (grant_rt) begin
            state_d = StMatch;
          end else if (count_q < EntriesC) begin
            state_d = StIssue;
          end else begin
            state_d = StDone;
            ok_d    = 1'b0;
          end
        end
      end
      StMatch: begin
        if (hit) begin
          state_d = StIssue;
        end else begin
          state_d = StDone;
          out_d   = '0;
          ok_d    = 1'b0;
          fail_d  = fail_q + 2'd1;
        end
      end
      StIssue: begin
        state_d = StWait;
        tmo_d   = '0;
      end
      StWait: begin
        if (eng_done) begin
          state_d = StDone;
          out_d   = eng_result;
          ok_d    = 1'b1;
          if (op_rt_q) begin
            fail_d = 2'd0;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + 4'd1;
          end
        end else if (tmo_q == TmoLast) begin
          state_d = StDone;
          out_d   = '0;
          ok_d    = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StDone:  state_d = (fail_q == 2'd3) ? StLock : StIdle;
      StLock:  state_d = StLock;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge msclk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      key_q     <= '0;
      code_q    <= '0;
      op_rt_q   <= 1'b0;
      last_rt_q <= 1'b1;
      mode_q    <= 1'b0;
      count_q   <= '0;
      fail_q    <= '0;
      out_q     <= '0;
      ok_q      <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      code_q    <= code_d;
      op_rt_q   <= op_rt_d;
      last_rt_q <= last_rt_d;
      mode_q    <= mode_d;
      count_q   <= count_d;
      fail_q    <= fail_d;
      out_q     <= out_d;
      ok_q      <= ok_d;
      tmo_q     <= tmo_d;
    end
  end

  always_ff @(posedge msclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_code_q[i] <= '0;
        tbl_key_q[i]  <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (4'(i) == count_q) begin
          tbl_code_q[i] <= eng_result;
          tbl_key_q[i]  <= key_q;
        end
      end
    end
  end

  assign eng_start = (state_q == StIssue);
  assign eng_mode  = mode_q;
  assign eng_key   = key_q;
  assign eng_data  = code_q;
  assign st_ack    = (state_q == StDone) && !op_rt_q;
  assign rt_ack    = (state_q == StDone) && op_rt_q;
  assign code_out  = out_q;
  assign result_ok = ok_q;
  assign fail_cnt  = fail_q;
  assign locked    = (state_q == StLock);
  assign count     = count_q;

endmodule

// File: tb/tb_vault_ctrl.sv
// Directed bench for vault_ctrl: XOR cipher-engine model plus a scoreboard of expected
// acknowledge results, compared with immediate assertions.
module tb_vault_ctrl;

  localparam int unsigned TMO_TB = 255;

  logic        msclk = 1'b0;
  logic        rst;
  logic        st_req, rt_req;
  logic [7:0]  key;
  logic [79:0] code_in;
  logic        eng_start, eng_mode;
  logic [7:0]  eng_key;
  logic [79:0] eng_data;
  logic        eng_done, eng_done_m, inj_done;
  logic [79:0] eng_result;
  logic        st_ack, rt_ack;
  logic [79:0] code_out;
  logic        result_ok;
  logic [1:0]  fail_cnt;
  logic        locked;
  logic [3:0]  count;

  vault_ctrl #(.ENTRIES(10), .TMO(TMO_TB)) dut (
    .msclk      (msclk),
    .rst        (rst),
    .st_req     (st_req),
    .rt_req     (rt_req),
    .key        (key),
    .code_in    (code_in),
    .eng_start  (eng_start),
    .eng_mode   (eng_mode),
    .eng_key    (eng_key),
    .eng_data   (eng_data),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .st_ack     (st_ack),
    .rt_ack     (rt_ack),
    .code_out   (code_out),
    .result_ok  (result_ok),
    .fail_cnt   (fail_cnt),
    .locked     (locked),
    .count      (count)
  );

  always #5 msclk = ~msclk;

  int cyc = 0;
  always @(posedge msclk) cyc <= cyc + 1;

  assign eng_done = eng_done_m | inj_done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          rt;
    logic [79:0] code;
    bit          ok;
    logic [3:0]  cnt;
    logic [1:0]  fail;
  } exp_t;
  exp_t sb[$];

  // Engine model: XOR with the key replicated, so decrypt(encrypt(c)) == c.
  bit          eng_mute = 1'b0;
  int          eng_lat  = 4;
  int          start_cnt = 0;
  int          start_cyc = 0;
  int          done_cyc  = 0;
  int          ack_cyc   = 0;
  logic        m_mode;
  logic [7:0]  m_key;
  logic [79:0] m_data;

  function automatic logic [79:0] rep(input logic [7:0] k);
    return {10{k}};
  endfunction

  initial begin
    bit aborted;
    eng_done_m = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge msclk);
      eng_done_m = 1'b0;
      if (eng_start && !rst) begin
        start_cnt++;
        start_cyc = cyc;
        m_mode = eng_mode;
        m_key  = eng_key;
        m_data = eng_data;
        if (!eng_mute) begin
          aborted = 1'b0;
          for (int i = 0; i < eng_lat; i++) begin
            @(negedge msclk);
            if (rst) aborted = 1'b1;
          end
          if (!aborted && !rst) begin
            eng_result = m_data ^ rep(m_key);
            eng_done_m = 1'b1;
            done_cyc   = cyc;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit rt, input logic [79:0] c, input bit ok, input logic [3:0] cn,
                      input logic [1:0] fl);
    exp_t e;
    e.rt = rt; e.code = c; e.ok = ok; e.cnt = cn; e.fail = fl;
    sb.push_back(e);
  endtask

  // Waits (bounded) for an ack, then compares it against the oldest expected result.
  task automatic finish_op(input string tag, input int limit);
    bit   got;
    exp_t e;
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge msclk);
      if (st_ack || rt_ack) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, ".ack_seen"}, 80'(got), 80'(1));
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      ack_cyc = cyc;
      check({tag, ".rt_ack"}, 80'(rt_ack), 80'(e.rt));
      check({tag, ".st_ack"}, 80'(st_ack), 80'(!e.rt));
      check({tag, ".code_out"}, code_out, e.code);
      check({tag, ".result_ok"}, 80'(result_ok), 80'(e.ok));
      check({tag, ".count"}, 80'(count), 80'(e.cnt));
      check({tag, ".fail_cnt"}, 80'(fail_cnt), 80'(e.fail));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".eng_start"}, 80'(eng_start), 80'(0));
    check({tag, ".eng_mode"}, 80'(eng_mode), 80'(0));
    check({tag, ".eng_key"}, 80'(eng_key), 80'(0));
    check({tag, ".eng_data"}, eng_data, 80'(0));
    check({tag, ".acks"}, 80'({st_ack, rt_ack}), 80'(0));
    check({tag, ".code_out"}, code_out, 80'(0));
    check({tag, ".result_ok"}, 80'(result_ok), 80'(0));
    check({tag, ".count"}, 80'(count), 80'(0));
    check({tag, ".fail_cnt"}, 80'(fail_cnt), 80'(0));
    check({tag, ".locked"}, 80'(locked), 80'(0));
  endtask

  initial begin
    logic [79:0] c1, r1, c2, last_code, saved_enc, saved_code, tmp;
    logic [95:0] rnd;
    logic [7:0]  k1, saved_key;
    int          g, s0, acks;

    rst = 1'b1; st_req = 1'b0; rt_req = 1'b0; key = 8'hA5; code_in = '1; inj_done = 1'b0;
    repeat (3) @(negedge msclk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge msclk);

    // Store: grant -> eng_start next cycle, ack the cycle after eng_done.
    c1 = 80'h3C57_7412_9AEF_0B6D_C83B;
    k1 = 8'h05;
    r1 = c1 ^ rep(k1);
    eng_lat = 4;
    key = k1; code_in = c1; st_req = 1'b1; g = cyc;
    push(1'b0, r1, 1'b1, 4'd1, 2'd0);
    @(negedge msclk);
    key = 8'hFF; code_in = '1;
    finish_op("store1", 50);
    st_req = 1'b0;
    check("store1.start_lat", 80'(start_cyc - g), 80'(1));
    check("store1.eng_mode", 80'(m_mode), 80'(0));
    check("store1.eng_key", 80'(m_key), 80'(k1));
    check("store1.eng_data", m_data, c1);
    check("store1.ack_lat", 80'(ack_cyc - done_cyc), 80'(1));
    @(negedge msclk);
    check("store1.ack_pulse", 80'(st_ack), 80'(0));

    // Retrieve hit decrypts back to the original code.
    key = k1; code_in = r1; rt_req = 1'b1; g = cyc;
    push(1'b1, c1, 1'b1, 4'd1, 2'd0);
    finish_op("rt_hit", 50);
    rt_req = 1'b0;
    check("rt_hit.start_lat", 80'(start_cyc - g), 80'(2));
    check("rt_hit.eng_mode", 80'(m_mode), 80'(1));
    check("rt_hit.eng_data", m_data, r1);
    @(negedge msclk);

    // Retrieve miss: no engine command.
    s0 = start_cnt;
    key = 8'h06; code_in = r1; rt_req = 1'b1;
    push(1'b1, '0, 1'b0, 4'd1, 2'd1);
    finish_op("rt_miss1", 50);
    rt_req = 1'b0;
    check("rt_miss1.no_start", 80'(start_cnt), 80'(s0));
    @(negedge msclk);

    // Stray eng_done while idle is ignored.
    inj_done = 1'b1;
    @(negedge msclk);
    inj_done = 1'b0;
    acks = 0;
    repeat (3) begin
      @(negedge msclk);
      if (st_ack || rt_ack) acks++;
    end
    check("stray_done.acks", 80'(acks), 80'(0));
    check("stray_done.count", 80'(count), 80'(1));

    for (int i = 2; i <= 3; i++) begin
      key = 8'h06; code_in = r1; rt_req = 1'b1;
      push(1'b1, '0, 1'b0, 4'd1, 2'(i));
      finish_op("rt_miss", 50);
      rt_req = 1'b0;
      @(negedge msclk);
    end
    check("lock.locked", 80'(locked), 80'(1));
    s0 = start_cnt;
    acks = 0;
    st_req = 1'b1; rt_req = 1'b1;
    repeat (20) begin
      @(negedge msclk);
      if (st_ack || rt_ack) acks++;
    end
    st_req = 1'b0; rt_req = 1'b0;
    check("lock.acks", 80'(acks), 80'(0));
    check("lock.no_start", 80'(start_cnt), 80'(s0));
    check("lock.still_locked", 80'(locked), 80'(1));

    rst = 1'b1;
    @(negedge msclk);
    rst = 1'b0;
    check("unlock.locked", 80'(locked), 80'(0));
    check("unlock.fail_cnt", 80'(fail_cnt), 80'(0));

    // Both requests held: store, retrieve, store.
    c2 = 80'h0123_4567_89AB_CDEF_1357;
    key = 8'h3A; code_in = c2; st_req = 1'b1; rt_req = 1'b1;
    eng_lat = 2;
    push(1'b0, c2 ^ rep(8'h3A), 1'b1, 4'd1, 2'd0);
    push(1'b1, '0, 1'b0, 4'd1, 2'd1);
    push(1'b0, c2 ^ rep(8'h3A), 1'b1, 4'd2, 2'd1);
    finish_op("rr1_store", 50);
    finish_op("rr2_retrieve", 50);
    finish_op("rr3_store", 50);
    st_req = 1'b0; rt_req = 1'b0;
    @(negedge msclk);

    saved_enc = '0; saved_code = '0; saved_key = '0; last_code = '0;
    for (int i = 2; i <= 9; i++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      tmp = rnd[79:0];
      key = 8'(i + 8'h40); code_in = tmp;
      eng_lat = int'($urandom_range(1, 6));
      last_code = tmp ^ rep(key);
      if (i == 5) begin
        saved_enc = last_code; saved_code = tmp; saved_key = key;
      end
      push(1'b0, last_code, 1'b1, 4'(i + 1), 2'd1);
      st_req = 1'b1;
      finish_op("fill", 50);
      st_req = 1'b0;
      @(negedge msclk);
    end

    // Table full: ack without engine, code_out keeps its last value.
    s0 = start_cnt;
    key = 8'h77; code_in = c1; st_req = 1'b1;
    push(1'b0, last_code, 1'b0, 4'd10, 2'd1);
    finish_op("store_full", 50);
    st_req = 1'b0;
    check("store_full.no_start", 80'(start_cnt), 80'(s0));
    @(negedge msclk);

    // Retrieve a middle entry; decrypt success clears fail_cnt.
    key = saved_key; code_in = saved_enc; rt_req = 1'b1;
    push(1'b1, saved_code, 1'b1, 4'd10, 2'd0);
    finish_op("rt_mid", 50);
    rt_req = 1'b0;
    @(negedge msclk);

    // Timeout in WAIT.
    rst = 1'b1;
    @(negedge msclk);
    rst = 1'b0;
    eng_lat = 3;
    key = k1; code_in = c1; st_req = 1'b1;
    push(1'b0, r1, 1'b1, 4'd1, 2'd0);
    finish_op("pre_tmo", 50);
    st_req = 1'b0;
    @(negedge msclk);
    eng_mute = 1'b1;
    key = 8'h11; code_in = c2; st_req = 1'b1;
    push(1'b0, '0, 1'b0, 4'd1, 2'd0);
    finish_op("timeout", 400);
    st_req = 1'b0;
    check("timeout.ack_lat", 80'(ack_cyc - start_cyc), 80'(TMO_TB + 1));
    @(negedge msclk);

    // Reset while waiting on the engine.
    s0 = start_cnt;
    st_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge msclk);
      if (start_cnt != s0) break;
    end
    check("rst_wait.started", 80'(start_cnt), 80'(s0 + 1));
    repeat (5) @(negedge msclk);
    rst = 1'b1;
    st_req = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    @(negedge msclk);
    rst = 1'b0;
    inj_done = 1'b1;
    @(negedge msclk);
    inj_done = 1'b0;
    acks = 0;
    repeat (10) begin
      @(negedge msclk);
      if (st_ack || rt_ack) acks++;
    end
    check("rst_wait.acks", 80'(acks), 80'(0));
    check("rst_wait.count", 80'(count), 80'(0));
    check("rst_wait.result_ok", 80'(result_ok), 80'(0));
    check("scoreboard.empty", 80'(sb.size()), 80'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
